// File: rtl/lut_cluster_cfg.sv
// Cluster of NUM_LUT K-input LUTs with per-input crossbar and optional output
// flip-flops, configured through a word-wide daisy-chainable shift chain.
`timescale 1ns/1ps
module lut_cluster_cfg #(
    parameter int NUM_LUT = 4,
    parameter int LUT_K   = 4,
    parameter int IN_W    = 16,
    parameter int CW      = 32
) (
    input  logic               clk,
    input  logic               res,
    input  logic [CW-1:0]      prog_i,
    input  logic               prog_shft,
    output logic [CW-1:0]      prog_o,
    input  logic [IN_W-1:0]    data_i,
    input  logic               ce,
    output logic [NUM_LUT-1:0] data_o,
    output logic               cfg_valid,
    output logic               cfg_err
);
    localparam int SEL_W = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int TT_W  = 1 << LUT_K;
    localparam int LB    = TT_W + LUT_K * SEL_W + 2;
    localparam int TOT   = NUM_LUT * LB;
    localparam int DEPTH = (TOT + CW - 1) / CW;
    localparam int CFG_W = DEPTH * CW;
    localparam int CNT_W = $clog2(DEPTH + 2);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {UNCFG, SHIFT, RUN, ERR} state_t;

    logic [CFG_W-1:0]   cfg_q, cfg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               shft_q;
    state_t             state_q, state_d;
    logic [NUM_LUT-1:0] ff_q, ff_d;
    logic [NUM_LUT-1:0] lut_f;
    logic [NUM_LUT-1:0] reg_mode;
    logic [NUM_LUT-1:0] init_nxt;

    generate
        if (DEPTH > 1) begin : g_chain
            assign cfg_d = prog_shft ? {cfg_q[CFG_W-CW-1:0], prog_i} : cfg_q;
        end else begin : g_chain_one
            assign cfg_d = prog_shft ? prog_i : cfg_q;
        end
    endgenerate

    assign prog_o = cfg_q[CFG_W-1 -: CW];

    generate
        for (genvar gi = 0; gi < NUM_LUT; gi++) begin : g_lut
            localparam int B = gi * LB;
            logic [TT_W-1:0]  tt;
            logic [LUT_K-1:0] idx;

            assign tt           = cfg_q[B +: TT_W];
            assign reg_mode[gi] = cfg_q[B + LB - 2];
            // Init taken from the post-shift image so the last shift edge leaves the final value.
            assign init_nxt[gi] = cfg_d[B + LB - 1];

            for (genvar gj = 0; gj < LUT_K; gj++) begin : g_in
                logic [SEL_W-1:0] sel;
                assign sel = cfg_q[B + TT_W + gj * SEL_W +: SEL_W];
                assign idx[gj] = ({{(32 - SEL_W){1'b0}}, sel} < 32'(IN_W)) ? data_i[sel] : 1'b0;
            end

            assign lut_f[gi] = tt[idx];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ff_d    = ff_q;
        if (prog_shft) begin
            state_d = SHIFT;
            ff_d    = init_nxt;
            if (!shft_q) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            case (state_q)
                SHIFT: state_d = (cnt_q == CNT_FULL) ? RUN : ERR;
                RUN: begin
                    for (int i = 0; i < NUM_LUT; i++) begin
                        if (reg_mode[i] && ce) ff_d[i] = lut_f[i];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            cfg_q   <= '0;
            cnt_q   <= '0;
            shft_q  <= 1'b0;
            state_q <= UNCFG;
            ff_q    <= '0;
        end else begin
            cfg_q   <= cfg_d;
            cnt_q   <= cnt_d;
            shft_q  <= prog_shft;
            state_q <= state_d;
            ff_q    <= ff_d;
        end
    end

    assign cfg_valid = (state_q == RUN);
    assign cfg_err   = (state_q == ERR);
    assign data_o    = (state_q == RUN) ? ((ff_q & reg_mode) | (lut_f & ~reg_mode)) : '0;

endmodule

// File: tb/tb_lut_cluster_cfg.sv
// Scoreboard bench for lut_cluster_cfg at default parameters (LB=34, DEPTH=5, CW=32).
`timescale 1ns/1ps
module tb_lut_cluster_cfg;
    logic        clk = 1'b0;
    logic        res;
    logic [31:0] prog_i;
    logic        prog_shft;
    logic [31:0] prog_o;
    logic [15:0] data_i;
    logic        ce;
    logic [3:0]  data_o;
    logic        cfg_valid;
    logic        cfg_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    lut_cluster_cfg dut (
        .clk       (clk),
        .res       (res),
        .prog_i    (prog_i),
        .prog_shft (prog_shft),
        .prog_o    (prog_o),
        .data_i    (data_i),
        .ce        (ce),
        .data_o    (data_o),
        .cfg_valid (cfg_valid),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic sb_pop_check(input logic [31:0] obs);
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq(e.tag, obs, e.exp);
        end
    endtask

    task automatic check_outs(input string pfx, input logic [3:0] d, input logic v, input logic e);
        sb_push({pfx, ".data_o"}, 32'(d));
        sb_pop_check(32'(data_o));
        sb_push({pfx, ".cfg_valid"}, 32'(v));
        sb_pop_check(32'(cfg_valid));
        sb_push({pfx, ".cfg_err"}, 32'(e));
        sb_pop_check(32'(cfg_err));
    endtask

    task automatic check_prog_o(input string tag, input logic [31:0] exp);
        sb_push(tag, exp);
        sb_pop_check(prog_o);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [159:0] lut_img(input int i, input logic [15:0] tt,
                                             input logic [15:0] sels, input logic mode,
                                             input logic init);
        logic [159:0] v;
        int b;
        v = '0;
        b = i * 34;
        v[b +: 16]  = tt;
        v[b + 16 +: 16] = sels;
        v[b + 32]   = mode;
        v[b + 33]   = init;
        return v;
    endfunction

    // Words beyond the fifth are random filler; every edge must keep outputs gated.
    task automatic burst(input logic [159:0] img, input int n);
        $display("burst: %0d words", n);
        for (int k = 0; k < n; k++) begin
            prog_shft = 1'b1;
            prog_i = (k < 5) ? img[(4 - k) * 32 +: 32] : ($urandom | 32'h1);
            step();
            check_outs($sformatf("shift%0d", k), 4'h0, 1'b0, 1'b0);
        end
        prog_shft = 1'b0;
        prog_i    = '0;
    endtask

    logic [159:0] img0, img1;
    logic [31:0]  rb_word;

    initial begin
        res = 1'b1; prog_i = '0; prog_shft = 1'b0; data_i = '0; ce = 1'b0;
        img0 = lut_img(0, 16'h6996, 16'h3210, 1'b0, 1'b0);
        img1 = img0 | lut_img(1, 16'h8000, 16'h7654, 1'b1, 1'b1);

        // Reset with random inputs
        for (int c = 0; c < 2; c++) begin
            prog_shft = 1'($urandom_range(0, 1));
            prog_i    = $urandom;
            data_i    = 16'($urandom);
            ce        = 1'($urandom_range(0, 1));
            step();
            $display("reset cycle %0d", c);
            check_outs("rst", 4'h0, 1'b0, 1'b0);
            check_prog_o("rst.prog_o", 32'h0);
        end
        res = 1'b0; prog_shft = 1'b0; prog_i = '0; ce = 1'b0;
        step();
        check_outs("post_rst", 4'h0, 1'b0, 1'b0);
        check_prog_o("post_rst.prog_o", 32'h0);

        // XOR4 combinational
        data_i = 16'h0007;
        burst(img0, 5);
        step();
        check_outs("xor.valid", 4'h1, 1'b1, 1'b0);
        data_i = 16'h000F; #1;
        check_outs("xor.f", 4'h0, 1'b1, 1'b0);
        data_i = 16'h0001; #1;
        check_outs("xor.1", 4'h1, 1'b1, 1'b0);
        data_i = 16'hFFF8; #1;
        check_outs("xor.hi_ignored", 4'h1, 1'b1, 1'b0);

        // Registered AND4 with init 1
        data_i = 16'h0000;
        burst(img1, 5);
        step();
        check_outs("reg.init", 4'h2, 1'b1, 1'b0);
        data_i = 16'h00F0; ce = 1'b0;
        step();
        check_outs("reg.ce0_hold", 4'h2, 1'b1, 1'b0);
        data_i = 16'h0000; ce = 1'b1; #1;
        check_outs("reg.no_comb", 4'h2, 1'b1, 1'b0);
        step();
        check_outs("reg.ce1_load0", 4'h0, 1'b1, 1'b0);
        data_i = 16'h00F0;
        step();
        check_outs("reg.ce1_load1", 4'h2, 1'b1, 1'b0);
        ce = 1'b0;

        // Wrong-length bursts
        burst(img1, 4);
        step();
        check_outs("short", 4'h0, 1'b0, 1'b1);
        burst(img1, 7);
        step();
        check_outs("long", 4'h0, 1'b0, 1'b1);
        burst(img1, 5);
        step();
        check_outs("recover", 4'h2, 1'b1, 1'b0);

        // Readback: words come out of prog_o in write order
        $display("readback load");
        for (int k = 0; k < 5; k++) begin
            rb_word   = $urandom;
            sb_push($sformatf("readback%0d", k), rb_word);
            prog_i    = rb_word;
            prog_shft = 1'b1;
            step();
        end
        for (int k = 0; k < 5; k++) begin
            $display("readback word %0d", k);
            sb_pop_check(prog_o);
            prog_i    = '0;
            prog_shft = 1'b1;
            step();
        end
        check_prog_o("readback.drained", 32'h0);
        prog_shft = 1'b0;
        step();
        check_outs("readback.err", 4'h0, 1'b0, 1'b1);

        // Reset mid-burst, then a fresh burst with prog_shft held high throughout
        burst(img0, 10);
        step();
        for (int k = 0; k < 3; k++) begin
            prog_shft = 1'b1;
            prog_i    = $urandom | 32'h1;
            step();
        end
        res = 1'b1; prog_i = 32'hDEAD_BEEF;
        step();
        res = 1'b0;
        check_outs("midrst", 4'h0, 1'b0, 1'b0);
        check_prog_o("midrst.prog_o", 32'h0);
        data_i = 16'h0007;
        burst(img0, 5);
        step();
        check_outs("midrst.reload", 4'h1, 1'b1, 1'b0);

        check_eq("sb_drained", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/lut_cluster_cfg.md
Name: lut_cluster_cfg

Overview:
- Parametrised successor to the single logic slice: a cluster of NUM_LUT K-input LUTs with a per-LUT input crossbar and optional output flip-flops.
- Configured through the standard word-wide shift chain (prog_i / prog_shft / prog_o), so it can be daisy-chained with other fabric tiles.
- Adds features the old slice lacks: burst word counting, a config-valid flag, a config-error flag, output gating during programming, and a programmable flip-flop init value.

Parameters:
- NUM_LUT, 4, number of LUTs in the cluster.
- LUT_K, 4, inputs per LUT; truth table is 2^LUT_K bits.
- IN_W, 16, width of the routing input bus.
- CW, 32, config word width (prog_i / prog_o).
- Derived (localparam, not overridable):
  - SEL_W = max(1, clog2(IN_W)).
  - LB = 2^LUT_K + LUT_K*SEL_W + 2, config bits per LUT.
  - TOT = NUM_LUT*LB.
  - DEPTH = ceil(TOT/CW). Defaults: LB=34, TOT=136, DEPTH=5.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- res  in  1  synchronous reset, active-high.
- prog_i  in  CW  config word in.
- prog_shft  in  1  shift enable for the config chain.
- prog_o  out  CW  config word out, to the next tile.
- data_i  in  IN_W  routing inputs.
- ce  in  1  clock enable for the LUT output flip-flops.
- data_o  out  NUM_LUT  LUT outputs.
- cfg_valid  out  1  a complete, exact-length configuration is loaded.
- cfg_err  out  1  the last burst had the wrong word count.

Behaviour:
- Reset (res=1 at an edge; overrides everything, including mid-burst):
  - cfg chain, word counter, output flip-flops, cfg_valid and cfg_err all go to 0.
  - Consequently data_o=0 and prog_o=0.
- Chain storage:
  - cfg[DEPTH*CW-1:0].
  - Each cycle with prog_shft=1: cfg <= {cfg[(DEPTH-1)*CW-1:0], prog_i}.
  - prog_o = cfg[DEPTH*CW-1 -: CW], purely from registers. The first word written exits prog_o after DEPTH further shifts (readback).
- Field map for LUT i, base b=i*LB:
  - Truth table: cfg[b +: 2^K], indexed by {in[K-1],...,in[0]}.
  - Select j: cfg[b+2^K+j*SEL_W +: SEL_W].
  - Register-mode bit: cfg[b+LB-2].
  - Init bit: cfg[b+LB-1].
  - Bits at and above TOT are padding and are ignored.
- LUT input j of LUT i = data_i[sel_j]. If sel_j >= IN_W, the input reads 0.
- Word counter cnt (width clog2(DEPTH+2)):
  - First cycle of a burst (prog_shft=1 with prog_shft low the previous cycle, or the first prog_shft after reset): cnt <= 1.
  - Later cycles of the burst: cnt <= cnt+1, saturating at DEPTH+1.
- State machine:
  - UNCFG: after reset.
  - SHIFT: prog_shft=1.
  - RUN: cfg_valid=1.
  - ERR: cfg_err=1.
  - Transitions:
    - Any state -> SHIFT on prog_shft=1. On that edge cfg_valid <= 0 and cfg_err <= 0.
    - SHIFT -> RUN on the first cycle with prog_shft=0, if cnt==DEPTH. cfg_valid rises at the next edge (1-cycle latency).
    - SHIFT -> ERR otherwise (short or over-long burst). cfg_err rises at the next edge; cfg_valid stays 0.
- While in SHIFT:
  - data_o forced to 0.
  - Each output flip-flop loads its LUT's current init bit on every shift edge, so after the burst it holds the final init value.
- In UNCFG or ERR:
  - data_o = 0.
  - Flip-flops hold their value.
- In RUN:
  - f_i = tt_i[index].
  - Register mode 0: data_o[i] = f_i, combinational from data_i with zero latency.
  - Register mode 1: q_i <= f_i on edges with ce=1, otherwise q_i holds; data_o[i] = q_i, 1-cycle latency.
- ce has no effect outside RUN.
- No combinational path from prog_i to prog_o.

Test Plan:
- Reset values: hold res=1 for 2 cycles with random inputs -> data_o=0, prog_o=0, cfg_valid=0, cfg_err=0; the cycle after release all outputs are still 0.
- XOR4 combinational: shift 5 words configuring LUT0 with tt=16'h6996, sel0..3 = 0,1,2,3, reg mode 0 (other LUTs all-zero).
  - cfg_valid=1 exactly one cycle after prog_shft falls.
  - data_i=16'h0007 -> data_o[0]=1; data_i=16'h000F -> data_o[0]=0, same cycle.
- Registered mode and init: LUT1 with tt=16'h8000 (AND4), sel=4,5,6,7, reg mode 1, init 1.
  - After the burst: data_o[1]=1.
  - data_i=16'h00F0 with ce=0 -> data_o[1] stays 1.
  - data_i=16'h0000 with ce=1 -> data_o[1]=0 one cycle later.
- Wrong length:
  - 4-word burst -> cfg_err=1, cfg_valid=0, data_o=0.
  - 7-word burst -> cfg_err=1.
  - A following correct 5-word burst clears cfg_err on its first shift edge and ends with cfg_valid=1.
- Readback: shift A0..A4, then shift 5 words of 0 -> prog_o shows A0, A1, A2, A3, A4 on successive cycles.
- Reset mid-burst: res=1 after 3 words -> cfg=0, cnt=0, data_o=0; a fresh 5-word burst then yields cfg_valid=1.
